// File: rtl/sprite_pkg.sv
// ============================================================================
// Module      : sprite_pkg
// Description : Sprite register map, address legality check and sequencer
//               state encoding shared by the commit sequencer and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

  localparam int DEPTH_DEFAULT = 4;

  localparam logic [5:0] SPR0_XY   = 6'h04;
  localparam logic [5:0] SPR0_BMP0 = 6'h06;
  localparam logic [5:0] SPR0_BMP1 = 6'h08;
  localparam logic [5:0] SPR0_BMP2 = 6'h0A;
  localparam logic [5:0] SPR0_BMP3 = 6'h0C;
  localparam logic [5:0] SPR1_XY   = 6'h0E;
  localparam logic [5:0] SPR1_BMP0 = 6'h10;
  localparam logic [5:0] SPR1_BMP1 = 6'h12;
  localparam logic [5:0] SPR1_BMP2 = 6'h14;
  localparam logic [5:0] SPR1_BMP3 = 6'h16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // The sprite map is a contiguous run of 16-bit registers, so even and in range is sufficient.
  function automatic logic addr_is_legal(input logic [31:0] addr);
    return (addr[0] == 1'b0) && (addr >= 32'(SPR0_XY)) && (addr <= 32'(SPR1_BMP3));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_cmd_fifo.sv
// ============================================================================
// Module      : sprite_cmd_fifo
// Description : Synchronous FIFO of {addr,data} commands; head is read
//               combinationally, occupancy is registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 22,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;

endmodule

`default_nettype wire

// File: rtl/sprite_commit_sequencer.sv
// ============================================================================
// Module      : sprite_commit_sequencer
// Description : Buffers CPU sprite-register writes and replays them onto the
//               register file only inside the blanking / stream-off window.
//               Define SPRITE_COMMIT_ATOMIC_EN for snapshot-per-frame commits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_commit_sequencer
  import sprite_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEFAULT,
  parameter int  AW    = 6,
  parameter int  DW    = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stream_en,
  input  logic          vblank,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          reg_we,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  output logic [CW-1:0] pending,
  output logic          overflow,
  input  logic          clr_overflow,
  output logic          commit_done
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic             r_alive;
  logic             r_reg_we;
  logic [AW-1:0]    r_reg_addr;
  logic [DW-1:0]    r_reg_wdata;
  logic             r_overflow;
  logic             r_commit_done;

  logic             w_legal;
  logic             w_window;
  logic             w_push;
  logic             w_pop;
  logic             w_drains_empty;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [AW+DW-1:0] w_head;

  assign w_legal        = addr_is_legal(32'(wr_addr));
  assign w_window       = !stream_en || vblank;
  // r_alive keeps wr_ready low while reset is asserted.
  assign wr_ready       = r_alive && !w_full;
  assign w_push         = wr_valid && wr_ready && w_legal;
  assign w_drains_empty = (w_count == CW'(1)) && !w_push;

  sprite_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AW + DW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({wr_addr, wr_data}),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

`ifdef SPRITE_COMMIT_ATOMIC_EN
  logic          r_window_q;
  logic [CW-1:0] r_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window_q <= 1'b0;
      r_snap     <= '0;
    end else begin
      r_window_q <= w_window;
      if (r_state == ST_ARMED && w_state_nxt == ST_DRAIN) r_snap <= w_count;
      else if (w_pop)                                     r_snap <= r_snap - CW'(1);
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: if (w_push) w_state_nxt = ST_ARMED;
`ifdef SPRITE_COMMIT_ATOMIC_EN
      ST_ARMED: if (w_window && !r_window_q) w_state_nxt = ST_DRAIN;
      // The snapshot is drained to completion even if the window has closed.
      ST_DRAIN: begin
        w_pop = !w_empty;
        if (r_snap == CW'(1)) w_state_nxt = w_drains_empty ? ST_IDLE : ST_ARMED;
      end
`else
      ST_ARMED: if (w_window) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!w_window) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_pop = !w_empty;
          if (w_drains_empty) w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_alive       <= 1'b0;
      r_reg_we      <= 1'b0;
      r_reg_addr    <= '0;
      r_reg_wdata   <= '0;
      r_overflow    <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_alive       <= 1'b1;
      r_reg_we      <= w_pop;
      r_commit_done <= w_pop && w_drains_empty;
      if (w_pop) {r_reg_addr, r_reg_wdata} <= w_head;
      // Set wins over clear; a pop in the same cycle does not make room for a full-FIFO write.
      if (wr_valid && (w_full || !w_legal)) r_overflow <= 1'b1;
      else if (clr_overflow)                r_overflow <= 1'b0;
    end
  end

  assign reg_we      = r_reg_we;
  assign reg_addr    = r_reg_addr;
  assign reg_wdata   = r_reg_wdata;
  assign pending     = w_count;
  assign overflow    = r_overflow;
  assign commit_done = r_commit_done;

endmodule

`default_nettype wire

// File: tb/tb_sprite_commit_sequencer.sv
// Directed scenarios plus random traffic, every cycle checked against a
// queue-based model of the buffered-commit rules.
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_commit_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stream_en = 1'b0;
  logic          vblank = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clr_overflow = 1'b0;
  logic          wr_ready;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [CW-1:0] pending;
  logic          overflow;
  logic          commit_done;

  int checks = 0;
  int errors = 0;

  sprite_commit_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stream_en    (stream_en),
    .vblank       (vblank),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .commit_done  (commit_done)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes as a queue, plus whether a drain is in progress.
  logic [AW+DW-1:0] q[$];
  bit               m_drain, m_alive, m_we, m_done, m_ovf;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data;
  int               we_seen, done_seen;
  logic [AW-1:0]    legal_tbl [10] = '{6'h04, 6'h06, 6'h08, 6'h0A, 6'h0C,
                                      6'h0E, 6'h10, 6'h12, 6'h14, 6'h16};

  function automatic bit is_legal(logic [AW-1:0] a);
    foreach (legal_tbl[i]) if (legal_tbl[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drain = 0; m_alive = 0; m_we = 0; m_done = 0; m_ovf = 0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic model_step();
    bit full, legal, window, push, pop;
    int remaining;
    full   = q.size() >= DEPTH;
    legal  = is_legal(wr_addr);
    window = !stream_en || vblank;
    push   = wr_valid && m_alive && !full && legal;
    pop    = m_drain && window && q.size() > 0;
    m_we   = pop;
    m_done = 0;
    if (pop) begin
      {m_addr, m_data} = q[0];
      m_done = (q.size() == 1) && !push;
    end
    if (wr_valid && (full || !legal)) m_ovf = 1;
    else if (clr_overflow)            m_ovf = 0;
    remaining = q.size() - int'(pop) + int'(push);
    if (m_drain) m_drain = window && remaining > 0;
    else         m_drain = q.size() > 0 && window;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back({wr_addr, wr_data});
    m_alive = 1;
  endtask

  task automatic check_all(string t);
    chk({t, ".wr_ready"},    wr_ready,    m_alive && q.size() < DEPTH);
    chk({t, ".reg_we"},      reg_we,      m_we);
    chk({t, ".reg_addr"},    reg_addr,    m_addr);
    chk({t, ".reg_wdata"},   reg_wdata,   m_data);
    chk({t, ".pending"},     pending,     q.size());
    chk({t, ".overflow"},    overflow,    m_ovf);
    chk({t, ".commit_done"}, commit_done, m_done);
  endtask

  task automatic tick(string t = "step");
    model_step();
    @(posedge clk);
    #1;
    check_all(t);
    if (reg_we)      we_seen++;
    if (commit_done) done_seen++;
  endtask

  task automatic push(logic [AW-1:0] a, logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick("push");
    wr_valid = 1'b0;
  endtask

  task automatic reset_check(string t);
    chk({t, ".wr_ready"},    wr_ready,    0);
    chk({t, ".reg_we"},      reg_we,      0);
    chk({t, ".reg_addr"},    reg_addr,    0);
    chk({t, ".reg_wdata"},   reg_wdata,   0);
    chk({t, ".pending"},     pending,     0);
    chk({t, ".overflow"},    overflow,    0);
    chk({t, ".commit_done"}, commit_done, 0);
    model_reset();
  endtask

  initial begin
    logic [AW-1:0] exp_addr [3];
    exp_addr[0] = 6'h0E; exp_addr[1] = 6'h10; exp_addr[2] = 6'h12;

    // Reset state
    #12;
    reset_check("reset");
    #1 rst_n = 1'b1;
    tick("idle");

    // Passthrough with streaming off
    push(6'h04, 16'h1020);
    tick("pass");
    tick("pass");
    chk("pass.reg_we", reg_we, 1);
    chk("pass.reg_addr", reg_addr, 6'h04);
    chk("pass.reg_wdata", reg_wdata, 16'h1020);
    chk("pass.commit_done", commit_done, 1);
    chk("pass.pending", pending, 0);

    // Deferred commit until vblank
    stream_en = 1'b1; vblank = 1'b0;
    for (int i = 0; i < 3; i++) push(exp_addr[i], 16'hA000 + 16'(i));
    we_seen = 0;
    repeat (100) tick("defer");
    chk("defer.no_we", we_seen, 0);
    chk("defer.pending", pending, 3);
    vblank = 1'b1;
    tick("defer.arm");
    for (int i = 0; i < 3; i++) begin
      tick("defer.drain");
      chk("defer.we", reg_we, 1);
      chk("defer.order", reg_addr, exp_addr[i]);
      chk("defer.done", commit_done, (i == 2));
    end
    vblank = 1'b0;

    // Window closes mid-drain
    for (int i = 0; i < 4; i++) push(legal_tbl[i], 16'hB000 + 16'(i));
    we_seen = 0; done_seen = 0;
    vblank = 1'b1;
    repeat (3) tick("close");
    vblank = 1'b0;
    repeat (3) tick("close.wait");
    chk("close.we_count", we_seen, 2);
    chk("close.pending", pending, 2);
    chk("close.no_done", done_seen, 0);
    vblank = 1'b1;
    repeat (3) tick("close.resume");
    chk("close.we_total", we_seen, 4);
    chk("close.done_total", done_seen, 1);
    vblank = 1'b0;

    // Full FIFO and overflow
    for (int i = 0; i < 4; i++) push(legal_tbl[9 - i], 16'hC000 + 16'(i));
    chk("full.wr_ready", wr_ready, 0);
    push(6'h04, 16'hDEAD);
    chk("full.overflow", overflow, 1);
    chk("full.pending", pending, 4);
    clr_overflow = 1'b1;
    tick("clr");
    clr_overflow = 1'b0;
    chk("clr.overflow", overflow, 0);
    vblank = 1'b1;
    repeat (6) tick("full.drain");
    vblank = 1'b0;
    chk("full.drained", pending, 0);

    // Illegal addresses
    push(6'h05, 16'h1111);
    push(6'h20, 16'h2222);
    chk("illegal.pending", pending, 0);
    chk("illegal.overflow", overflow, 1);
    clr_overflow = 1'b1;
    tick("clr2");
    clr_overflow = 1'b0;

    // Reset mid-drain
    for (int i = 0; i < 4; i++) push(legal_tbl[i + 2], 16'hE000 + 16'(i));
    vblank = 1'b1;
    tick("rst.arm");
    tick("rst.pop1");
    chk("rst.first_we", reg_we, 1);
    rst_n = 1'b0;
    #1;
    reset_check("rst.async");
    #2 rst_n = 1'b1;
    we_seen = 0;
    repeat (6) tick("rst.after");
    chk("rst.no_we", we_seen, 0);
    chk("rst.pending", pending, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) stream_en = ~stream_en;
      if ($urandom_range(0, 7) == 0)  vblank = ~vblank;
      wr_valid     = 1'($urandom_range(0, 1));
      wr_addr      = ($urandom_range(0, 9) != 0) ? legal_tbl[$urandom_range(0, 9)] : AW'($urandom);
      wr_data      = DW'($urandom);
      clr_overflow = ($urandom_range(0, 15) == 0);
      tick("rand");
    end
    wr_valid = 1'b0; clr_overflow = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_commit_sequencer.md
Name: sprite_commit_sequencer

Overview:
- Buffers CPU writes to the sprite register file (coords and 16-bit bitmap words) in a small FIFO.
- Replays the buffered writes onto the register-file write port only inside a safe window: vertical blanking, or any time streaming is disabled.
- Removes tearing from mid-frame sprite updates.
- Sits between the TinyQV bus decode and the sprite register file. Its commit_done pulse feeds the peripheral IRQ logic.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- AW, 6, register address width.
- DW, 16, register data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stream_en  in  1  control_reg[0]; 1 = video running
- vblank  in  1  high while v_cnt >= 768 (from timing generator)
- wr_valid  in  1  CPU write request (16-bit write decoded)
- wr_addr  in  AW  target register address
- wr_data  in  DW  write data
- wr_ready  out  1  FIFO can accept an entry this cycle
- reg_we  out  1  register-file write strobe
- reg_addr  out  AW  register-file address
- reg_wdata  out  DW  register-file data
- pending  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow  out  1  sticky: write attempted while full, or to an illegal address
- clr_overflow  in  1  clears overflow
- commit_done  out  1  one-cycle pulse when a drain empties the FIFO

Behaviour:
- Reset (asynchronous, rst_n low): all outputs are 0; the FIFO is flushed (pointers 0, pending=0); state is IDLE.
  - Reset mid-drain discards remaining entries with no further reg_we.
- Legal addresses: even values 0x04..0x16 only.
  - A wr_valid with an illegal address is not enqueued and sets overflow.
  - wr_ready is unaffected by illegal addresses.
- Write ready and push:
  - wr_ready = !full, computed from registered occupancy.
  - A push occurs when wr_valid && wr_ready && the address is legal.
  - wr_valid while full drops the write and sets overflow. This holds even if a pop occurs in the same cycle (no same-cycle refill when full).
- Commit window: window = !stream_en || vblank. Both inputs are sampled at the clock edge.
- States: IDLE (empty), ARMED (non-empty, waiting for window), DRAIN.
  - IDLE -> ARMED on a push.
  - ARMED -> DRAIN when window=1.
  - DRAIN -> ARMED when window=0 and entries remain.
  - DRAIN -> IDLE when the last entry is popped.
- Drain timing:
  - In DRAIN, each cycle with window=1 pops the head entry. The popped entry drives registered reg_we=1, reg_addr and reg_wdata on the following cycle.
  - Throughput is 1 entry per cycle.
  - Entries commit in strict FIFO order.
  - Duplicate addresses are not merged; the last write wins.
- Latency: a push at edge N followed by window=1 gives the earliest reg_we in cycle N+2 (ARMED->DRAIN edge, then the pop edge).
- Window closes mid-drain: no reg_we in the cycle after window=0 is sampled. Remaining entries wait for the next window.
- Pushes during DRAIN are allowed and are drained in the same window if it stays open.
- commit_done: asserted in the same cycle as the reg_we of the final entry, when pending reaches 0.
- reg_we is 0 whenever no pop occurred on the previous edge. reg_addr and reg_wdata hold their last values when reg_we=0.
- overflow:
  - Set has priority over clr_overflow in the same cycle.
  - Cleared only by clr_overflow or reset.
- pending: updates on every edge. A simultaneous push and pop leaves it unchanged.

Optional Feature:
- Macro: SPRITE_COMMIT_ATOMIC_EN.
- With the macro defined:
  - A drain may start only on the rising edge of vblank (or the falling edge of stream_en).
  - It commits exactly the entries present at that edge (a snapshot count).
  - Entries pushed after the snapshot wait for the next frame.
  - If vblank ends before the snapshot is exhausted, draining continues until the snapshot is complete; vblank lasts 38 lines, far exceeding DEPTH.
- Without the macro: the level-sensitive window behaviour described above.

Decomposition:
- Shared package sprite_pkg holds:
  - Register address localparams (SPR0_XY=0x04, SPR0_BMP0..3=0x06..0x0C, SPR1_XY=0x0E, SPR1_BMP0..3=0x10..0x16).
  - The address-legality function.
  - The state enum (IDLE/ARMED/DRAIN).
  - DEPTH default.
- One sub-module: sprite_cmd_fifo. It is a synchronous FIFO of {addr,data} with full, empty and count outputs and no output registering. The sequencer FSM and output registers stay in sprite_commit_sequencer.

Test Plan:
- Passthrough: stream_en=0; push (0x04,0x1020). Required: reg_we=1 with reg_addr=0x04, reg_wdata=0x1020 two cycles later; commit_done in the same cycle; pending returns to 0.
- Deferred commit: stream_en=1, vblank=0; push 3 entries. Required: pending=3 and no reg_we for 100 cycles. Then raise vblank. Required: 3 consecutive reg_we in push order; commit_done on the 3rd.
- Window closes mid-drain: 4 entries queued; vblank high for 2 drain cycles, then low. Required: exactly 2 reg_we, pending=2, no commit_done. Next vblank: remaining 2 commit.
- Full/overflow: vblank=0; push 5 writes. Required: wr_ready=0 after the 4th; 5th dropped; overflow=1; pending=4. Pulse clr_overflow. Required: overflow=0.
- Illegal address: push to 0x05 and to 0x20. Required: not enqueued; pending unchanged; overflow=1.
- Reset mid-drain: assert rst_n low during a 4-entry drain after 1 reg_we. Required: all outputs immediately 0; after release, pending=0 and no further reg_we.
